// File: rtl/io_timer.sv
// rtl/io_timer.sv - memory-mapped countdown timer with prescaler and level interrupt
// Four word registers behind a Read/Write/Ack strobe handshake.
module io_timer #(
  parameter int PRESCALE_W = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Read,
  input  logic        Write,
  input  logic [1:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ack,
  output logic        Interrupt
);

  typedef enum logic {S_IDLE, S_ACK} state_e;

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_LOAD  = 2'd1;
  localparam logic [1:0] A_COUNT = 2'd2;
  localparam logic [1:0] A_PRESC = 2'd3;

  state_e                  state_q, state_d;
  logic                    en_q, en_d;
  logic                    auto_q, auto_d;
  logic                    irqen_q, irqen_d;
  logic                    pend_q, pend_d;
  logic [31:0]             load_q, load_d;
  logic [31:0]             count_q, count_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
  logic [31:0]             dout_q, dout_d;

  logic        access, wr, wr_ctrl, wr_load, wr_count, wr_presc;
  logic        tick, tick_eff, expire;
  logic [31:0] rdata;
  logic [31:0] prescale_ext;

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    auto_d     = auto_q;
    irqen_d    = irqen_q;
    pend_d     = pend_q;
    load_d     = load_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    dout_d     = dout_q;

    // Only an IDLE strobe is an access, so a held strobe executes once.
    access   = (state_q == S_IDLE) && (Read || Write);
    wr       = access && Write;
    wr_ctrl  = wr && (Address == A_CTRL);
    wr_load  = wr && (Address == A_LOAD);
    wr_count = wr && (Address == A_COUNT);
    wr_presc = wr && (Address == A_PRESC);

    prescale_ext = '0;
    prescale_ext[PRESCALE_W-1:0] = prescale_q;

    unique case (Address)
      A_CTRL:  rdata = {28'h0, pend_q, irqen_q, auto_q, en_q};
      A_LOAD:  rdata = load_q;
      A_COUNT: rdata = count_q;
      default: rdata = prescale_ext;
    endcase

    unique case (state_q)
      S_IDLE:  if (access) state_d = S_ACK;
      default: if (!Read && !Write) state_d = S_IDLE;
    endcase

    if (access) dout_d = wr ? 32'h0 : rdata;

    // A direct COUNT write or a disabling CTRL write swallows a coincident tick.
    tick     = en_q && (pcnt_q == prescale_q);
    tick_eff = tick && !wr_count && !(wr_ctrl && !DataIn[0]);
    expire   = tick_eff && (count_q == 32'h0);

    if (en_q) pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    if (wr_presc || (wr_ctrl && DataIn[0] && !en_q)) pcnt_d = '0;

    if (tick_eff) begin
      if (count_q != 32'h0) count_d = count_q - 32'd1;
      else if (auto_q)      count_d = load_q;
      else                  en_d    = 1'b0;
    end

    if (wr_ctrl) begin
      en_d    = DataIn[0];
      auto_d  = DataIn[1];
      irqen_d = DataIn[2];
      if (DataIn[3]) pend_d = 1'b0;
    end
    if (wr_load)  load_d     = DataIn;
    if (wr_count) count_d    = DataIn;
    if (wr_presc) prescale_d = DataIn[PRESCALE_W-1:0];

    // Expiry is applied last so it beats a same-cycle write-1-to-clear.
    if (expire) pend_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      irqen_q    <= 1'b0;
      pend_q     <= 1'b0;
      load_q     <= 32'h0;
      count_q    <= 32'h0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      dout_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      irqen_q    <= irqen_d;
      pend_q     <= pend_d;
      load_q     <= load_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      dout_q     <= dout_d;
    end
  end

  assign Ack       = (state_q == S_ACK);
  assign DataOut   = dout_q;
  assign Interrupt = pend_q & irqen_q;

endmodule

// File: tb/tb_io_timer.sv
// tb/tb_io_timer.sv - directed self-checking bench for io_timer
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_timer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [1:0]  Address = 2'd0;
  logic [31:0] DataIn = 32'h0;
  logic [31:0] dout0, dout1;
  logic        ack0, ack1, irq0, irq1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] d;

  always #5 clock = ~clock;

  io_timer #(.PRESCALE_W(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .Read(Read), .Write(Write), .Address(Address),
    .DataIn(DataIn), .DataOut(dout0), .Ack(ack0), .Interrupt(irq0)
  );

  io_timer #(.PRESCALE_W(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .Read(Read), .Write(Write), .Address(Address),
    .DataIn(DataIn), .DataOut(dout1), .Ack(ack1), .Interrupt(irq1)
  );

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [1:0] a,
                     input logic [31:0] wd, input bit sel1, output logic [31:0] rdata);
    int   n;
    logic ack;
    Read = rd; Write = wr; Address = a; DataIn = wd; n = 0;
    do begin
      cyc();
      n++;
      ack = sel1 ? ack1 : ack0;
    end while (!ack && n < 4);
    if (!ack) begin
      checks++; errors++;
      $display("FAIL bus_ack_timeout: Ack 0 after %0d cycles, required 1", n);
    end
    rdata = sel1 ? dout1 : dout0;
    Read = 1'b0; Write = 1'b0;
    cyc();
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] v);
    logic [31:0] dummy;
    bus(1'b0, 1'b1, a, v, 1'b0, dummy);
  endtask

  task automatic rd_reg(input logic [1:0] a, input bit sel1, output logic [31:0] v);
    bus(1'b1, 1'b0, a, 32'h0, sel1, v);
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({ack0, irq0, dout0} !== 34'h0) begin
      errors++; $display("FAIL reset_outputs: got ack=%b irq=%b dout=%h, required 0", ack0, irq0, dout0);
    end
    reset_n = 1'b1;
    cyc();
    for (int a = 0; a < 4; a++) begin
      rd_reg(a[1:0], 1'b0, d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL reset_reg%0d: got %h, required 0", a, d);
      end
    end
  endtask

  task automatic test_periodic();
    wr_reg(3, 32'd0); wr_reg(1, 32'd3); wr_reg(2, 32'd3); wr_reg(0, 32'h7);
    repeat (2) cyc();
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL periodic_pre: irq %b, required 0", irq0); end
    cyc();
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL periodic_expiry: irq %b, required 1", irq0); end
    wr_reg(0, 32'hF);
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL periodic_w1c: irq %b, required 0", irq0); end
    cyc();
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL periodic_gap: irq %b, required 0", irq0); end
    cyc();
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL periodic_reexpiry: irq %b, required 1", irq0); end
    rd_reg(2, 1'b0, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL periodic_reload: count %h, required 3", d); end
  endtask

  task automatic test_oneshot();
    wr_reg(0, 32'h8); wr_reg(3, 32'd9); wr_reg(2, 32'd2); wr_reg(0, 32'h5);
    repeat (28) cyc();
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL oneshot_early: irq %b, required 0", irq0); end
    cyc();
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL oneshot_expiry: irq %b, required 1", irq0); end
    rd_reg(0, 1'b0, d);
    checks++;
    if (d !== 32'hC) begin errors++; $display("FAIL oneshot_ctrl: got %h, required c", d); end
    rd_reg(2, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL oneshot_count: got %h, required 0", d); end
    repeat (25) cyc();
    rd_reg(2, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL oneshot_stopped: got %h, required 0", d); end
  endtask

  task automatic test_handshake();
    wr_reg(2, 32'h55);
    Address = 2'd2; Read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (ack0 !== 1'b1 || dout0 !== 32'h55) begin
        errors++; $display("FAIL held_read_%0d: ack %b dout %h, required 1 00000055", i, ack0, dout0);
      end
    end
    Read = 1'b0;
    cyc();
    checks++;
    if (ack0 !== 1'b0 || dout0 !== 32'h55) begin
      errors++; $display("FAIL held_read_release: ack %b dout %h, required 0 00000055", ack0, dout0);
    end
    wr_reg(3, 32'd0); wr_reg(0, 32'h9);
    Address = 2'd2; DataIn = 32'd100; Write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (ack0 !== 1'b1 || dout0 !== 32'h0) begin
        errors++; $display("FAIL held_write_%0d: ack %b dout %h, required 1 0", i, ack0, dout0);
      end
    end
    Write = 1'b0;
    cyc();
    checks++;
    if (ack0 !== 1'b0) begin errors++; $display("FAIL held_write_release: ack %b, required 0", ack0); end
    rd_reg(2, 1'b0, d);
    checks++;
    if (d !== 32'd95) begin errors++; $display("FAIL held_write_once: count %0d, required 95", d); end
  endtask

  task automatic test_read_write_together();
    Address = 2'd1; DataIn = 32'h1234; Read = 1'b1; Write = 1'b1;
    cyc();
    checks++;
    if (ack0 !== 1'b1 || dout0 !== 32'h0) begin
      errors++; $display("FAIL rw_dout: ack %b dout %h, required 1 0", ack0, dout0);
    end
    Read = 1'b0; Write = 1'b0;
    cyc();
    rd_reg(1, 1'b0, d);
    checks++;
    if (d !== 32'h1234) begin errors++; $display("FAIL rw_load: got %h, required 1234", d); end
    wr_reg(0, 32'h8);
  endtask

  task automatic test_collisions();
    wr_reg(3, 32'd3); wr_reg(0, 32'h1);
    repeat (2) cyc();
    wr_reg(2, 32'h100);
    rd_reg(2, 1'b0, d);
    checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL count_write_on_tick: got %h, required 100", d); end
    wr_reg(0, 32'h8);
    wr_reg(3, 32'd0); wr_reg(2, 32'd2); wr_reg(0, 32'h7);
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL w1c_pre: irq %b, required 0", irq0); end
    cyc();
    wr_reg(0, 32'hF);
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL w1c_on_expiry: irq %b, required 1", irq0); end
    rd_reg(0, 1'b0, d);
    checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL w1c_ctrl: got %h, required f", d); end
    wr_reg(0, 32'h3);
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL irqen_clear: irq %b, required 0", irq0); end
    wr_reg(0, 32'h7);
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL irqen_set: irq %b, required 1", irq0); end
  endtask

  task automatic test_reset_mid_access();
    Address = 2'd1; Read = 1'b1;
    cyc();
    checks++;
    if (ack0 !== 1'b1 || dout0 !== 32'h1234) begin
      errors++; $display("FAIL mid_access_pre: ack %b dout %h, required 1 00001234", ack0, dout0);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ack0, irq0, dout0} !== 34'h0) begin
      errors++; $display("FAIL async_reset: ack %b irq %b dout %h, required 0", ack0, irq0, dout0);
    end
    #1 reset_n = 1'b1;
    cyc();
    checks++;
    if (ack0 !== 1'b1 || dout0 !== 32'h0) begin
      errors++; $display("FAIL post_reset_access: ack %b dout %h, required 1 0", ack0, dout0);
    end
    Read = 1'b0;
    cyc();
    for (int a = 0; a < 4; a++) begin
      rd_reg(a[1:0], 1'b0, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL post_reset_reg%0d: got %h, required 0", a, d); end
    end
  endtask

  task automatic test_param_corner();
    logic [31:0] exp_cnt;
    wr_reg(3, 32'd1); wr_reg(2, 32'd100); wr_reg(0, 32'h1);
    exp_cnt = 32'd100;
    for (int i = 0; i < 3; i++) begin
      rd_reg(2, 1'b1, d);
      checks++;
      if (d !== exp_cnt) begin errors++; $display("FAIL w1_tick_%0d: count %0d, required %0d", i, d, exp_cnt); end
      exp_cnt = exp_cnt - 32'd1;
    end
    rd_reg(3, 1'b1, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL w1_prescale: got %h, required 1", d); end
    checks++;
    if (irq1 !== 1'b0) begin errors++; $display("FAIL w1_irq: irq %b, required 0", irq1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_handshake();
    test_read_write_together();
    test_collisions();
    test_reset_mid_access();
    test_param_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
